// File: rtl/rc4_key_search_ctrl.sv
// Sequencer for an RC4 brute-force key search: steps each candidate key through the
// init / KSA / decrypt engines, with watchdog, attempt count and S-memory arbitration.
module rc4_key_search_ctrl #(
  parameter int KEY_W       = 24,
  parameter int KEY_STRIDE  = 1,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [KEY_W-1:0]    key_start,
  input  logic [KEY_W-1:0]    key_end,
  output logic [KEY_W-1:0]    key,
  output logic [KEY_W-1:0]    found_key,
  output logic [KEY_W-1:0]    attempts,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic                exhausted,
  output logic                aborted,
  output logic                timeout_err,
  output logic [2:0]          phase_start,
  input  logic [2:0]          phase_done,
  output logic [2:0]          phase_ack,
  input  logic                match,
  input  logic [3*ADDR_W-1:0] eng_addr,
  input  logic [3*DATA_W-1:0] eng_wdata,
  input  logic [2:0]          eng_wren,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic                s_wren
);

  typedef enum logic [1:0] {IDLE, START_PH, WAIT_PH, DONE} state_e;

  localparam logic [KEY_W-1:0] STRIDE_C = KEY_W'(KEY_STRIDE);
  localparam logic [31:0]      TMO_C    = 32'(TIMEOUT_CYC);

  state_e             state_q, state_d;
  logic [1:0]         ph_q, ph_d;
  logic [KEY_W-1:0]   key_q, key_d, key_end_q, key_end_d;
  logic [KEY_W-1:0]   found_key_q, found_key_d, attempts_q, attempts_d;
  logic               found_q, found_d, exh_q, exh_d, abt_q, abt_d, tmo_q, tmo_d;
  logic [31:0]        wd_q, wd_d;
  logic [2:0]         ack_q, ack_d;
  logic [ADDR_W-1:0]  s_addr_q, s_addr_d;
  logic [DATA_W-1:0]  s_wdata_q, s_wdata_d;
  logic               s_wren_q, s_wren_d;
  logic               done_s, timeout_s;

  function automatic logic [2:0] ph_onehot(input logic [1:0] p);
    case (p)
      2'd0:    ph_onehot = 3'b001;
      2'd1:    ph_onehot = 3'b010;
      2'd2:    ph_onehot = 3'b100;
      default: ph_onehot = 3'b000;
    endcase
  endfunction

  // State, datapath and arbiter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ph_q        <= 2'd0;
      key_q       <= '0;
      key_end_q   <= '0;
      found_key_q <= '0;
      attempts_q  <= '0;
      found_q     <= 1'b0;
      exh_q       <= 1'b0;
      abt_q       <= 1'b0;
      tmo_q       <= 1'b0;
      wd_q        <= 32'd0;
      ack_q       <= 3'b000;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      s_wren_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      key_q       <= key_d;
      key_end_q   <= key_end_d;
      found_key_q <= found_key_d;
      attempts_q  <= attempts_d;
      found_q     <= found_d;
      exh_q       <= exh_d;
      abt_q       <= abt_d;
      tmo_q       <= tmo_d;
      wd_q        <= wd_d;
      ack_q       <= ack_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_wren_q    <= s_wren_d;
    end
  end

  // Next-state logic: sequencing, termination priority and watchdog
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    key_d       = key_q;
    key_end_d   = key_end_q;
    found_key_d = found_key_q;
    attempts_d  = attempts_q;
    found_d     = found_q;
    exh_d       = exh_q;
    abt_d       = abt_q;
    tmo_d       = tmo_q;
    wd_d        = wd_q;
    ack_d       = 3'b000;
    done_s      = |(phase_done & ph_onehot(ph_q));
    timeout_s   = (TMO_C != 32'd0) && !done_s && ((wd_q + 32'd1) >= TMO_C);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          key_d       = key_start;
          key_end_d   = key_end;
          attempts_d  = '0;
          found_key_d = '0;
          found_d     = 1'b0;
          abt_d       = 1'b0;
          tmo_d       = 1'b0;
          ph_d        = 2'd0;
          if (key_start > key_end) begin
            exh_d   = 1'b1;
            state_d = DONE;
          end else begin
            exh_d   = 1'b0;
            state_d = START_PH;
          end
        end else begin
          state_d = state_q;
        end
      end
      START_PH: begin
        wd_d = 32'd0;
        if (abort) begin
          abt_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = WAIT_PH;
        end
      end
      WAIT_PH: begin
        wd_d = wd_q + 32'd1;
        if (done_s) begin
          ack_d = ph_onehot(ph_q);
        end else begin
          ack_d = 3'b000;
        end
        // A finished key counts as an attempt whatever terminates the search
        if (done_s && ph_q == 2'd2 && attempts_q != {KEY_W{1'b1}}) begin
          attempts_d = attempts_q + {{(KEY_W-1){1'b0}}, 1'b1};
        end else begin
          attempts_d = attempts_q;
        end
        if (done_s && ph_q == 2'd2 && match) begin
          found_d     = 1'b1;
          found_key_d = key_q;
          state_d     = DONE;
        end else if (abort) begin
          abt_d   = 1'b1;
          state_d = DONE;
        end else if (timeout_s) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end else if (done_s) begin
          if (ph_q != 2'd2) begin
            ph_d    = ph_q + 2'd1;
            state_d = START_PH;
          end else if ((key_end_q - key_q) < STRIDE_C) begin
            exh_d   = 1'b1;
            state_d = DONE;
          end else begin
            key_d   = key_q + STRIDE_C;
            ph_d    = 2'd0;
            state_d = START_PH;
          end
        end else begin
          state_d = WAIT_PH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // S-memory arbiter: follow the engine that will own the next cycle
  always_comb begin
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_wren_d  = 1'b0;
    if (state_d == START_PH || state_d == WAIT_PH) begin
      case (ph_d)
        2'd0: begin
          s_addr_d  = eng_addr[ADDR_W-1:0];
          s_wdata_d = eng_wdata[DATA_W-1:0];
          s_wren_d  = eng_wren[0];
        end
        2'd1: begin
          s_addr_d  = eng_addr[2*ADDR_W-1:ADDR_W];
          s_wdata_d = eng_wdata[2*DATA_W-1:DATA_W];
          s_wren_d  = eng_wren[1];
        end
        2'd2: begin
          s_addr_d  = eng_addr[3*ADDR_W-1:2*ADDR_W];
          s_wdata_d = eng_wdata[3*DATA_W-1:2*DATA_W];
          s_wren_d  = eng_wren[2];
        end
        default: s_wren_d = 1'b0;
      endcase
    end else begin
      s_wren_d = 1'b0;
    end
  end

  assign key         = key_q;
  assign found_key   = found_key_q;
  assign attempts    = attempts_q;
  assign busy        = (state_q == START_PH) || (state_q == WAIT_PH);
  assign done        = (state_q == DONE);
  assign found       = found_q;
  assign exhausted   = exh_q;
  assign aborted     = abt_q;
  assign timeout_err = tmo_q;
  assign phase_start = (state_q == START_PH) ? ph_onehot(ph_q) : 3'b000;
  assign phase_ack   = ack_q;
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign s_wren      = s_wren_q;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Directed bench for rc4_key_search_ctrl: two instances (stride 1 with a 16-cycle
// watchdog, stride 4 without) driven by simple delayed-done engine models.
module tb_rc4_key_search_ctrl;
  localparam int KW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b0;

  logic [23:0] eaddr  = 24'hA2A1A0;
  logic [23:0] ewdata = 24'hD2D1D0;
  logic [2:0]  ewren  = 3'b111;

  logic          start_a = 1'b0, abort_a = 1'b0;
  logic [KW-1:0] ks_a = '0, ke_a = '0, key_a, fkey_a, att_a;
  logic          busy_a, done_a, found_a, exh_a, abt_a, to_a, match_a, swren_a;
  logic [2:0]    ps_a, pa_a;
  logic [2:0]    pd_a = 3'b000;
  logic [7:0]    saddr_a, swdata_a;
  logic [2:0]    hang_a = 3'b000;
  logic          match_en_a = 1'b0;
  logic [KW-1:0] match_key_a = '0;
  assign match_a = match_en_a && (key_a == match_key_a);

  logic          start_b = 1'b0, abort_b = 1'b0;
  logic [KW-1:0] ks_b = '0, ke_b = '0, key_b, fkey_b, att_b;
  logic          busy_b, done_b, found_b, exh_b, abt_b, to_b, swren_b;
  logic          match_b = 1'b0;
  logic [2:0]    ps_b, pa_b;
  logic [2:0]    pd_b = 3'b000;
  logic [7:0]    saddr_b, swdata_b;

  rc4_key_search_ctrl #(.KEY_W(KW), .KEY_STRIDE(1), .ADDR_W(8), .DATA_W(8), .TIMEOUT_CYC(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort_a),
    .key_start(ks_a), .key_end(ke_a), .key(key_a), .found_key(fkey_a), .attempts(att_a),
    .busy(busy_a), .done(done_a), .found(found_a), .exhausted(exh_a), .aborted(abt_a),
    .timeout_err(to_a), .phase_start(ps_a), .phase_done(pd_a), .phase_ack(pa_a),
    .match(match_a), .eng_addr(eaddr), .eng_wdata(ewdata), .eng_wren(ewren),
    .s_addr(saddr_a), .s_wdata(swdata_a), .s_wren(swren_a));

  rc4_key_search_ctrl #(.KEY_W(KW), .KEY_STRIDE(4), .ADDR_W(8), .DATA_W(8), .TIMEOUT_CYC(0)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort_b),
    .key_start(ks_b), .key_end(ke_b), .key(key_b), .found_key(fkey_b), .attempts(att_b),
    .busy(busy_b), .done(done_b), .found(found_b), .exhausted(exh_b), .aborted(abt_b),
    .timeout_err(to_b), .phase_start(ps_b), .phase_done(pd_b), .phase_ack(pa_b),
    .match(match_b), .eng_addr(eaddr), .eng_wdata(ewdata), .eng_wren(ewren),
    .s_addr(saddr_b), .s_wdata(swdata_b), .s_wren(swren_b));

  // Engine models: done 5 cycles after start, held until acked; also log activity
  int cnt_a[3], cnt_b[3];
  int n_done_a[3], n_ack_a[3];
  logic [2:0]    ps_log_a[$];
  logic [KW-1:0] key_log_b[$];

  always @(negedge clk) begin
    if (!reset_n) begin
      pd_a = 3'b000;
      for (int i = 0; i < 3; i++) cnt_a[i] = 0;
    end else begin
      if (ps_a != 3'b000) ps_log_a.push_back(ps_a);
      for (int i = 0; i < 3; i++) begin
        if (pa_a[i]) begin
          n_ack_a[i]++;
          pd_a[i] = 1'b0;
        end
        if (ps_a[i]) cnt_a[i] = 5;
        else if (cnt_a[i] > 0) begin
          cnt_a[i]--;
          if (cnt_a[i] == 0 && !hang_a[i]) begin
            pd_a[i] = 1'b1;
            n_done_a[i]++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      pd_b = 3'b000;
      for (int j = 0; j < 3; j++) cnt_b[j] = 0;
    end else begin
      if (ps_b[0]) key_log_b.push_back(key_b);
      for (int j = 0; j < 3; j++) begin
        if (pa_b[j]) pd_b[j] = 1'b0;
        if (ps_b[j]) cnt_b[j] = 5;
        else if (cnt_b[j] > 0) begin
          cnt_b[j]--;
          if (cnt_b[j] == 0) pd_b[j] = 1'b1;
        end
      end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_search_a(input logic [KW-1:0] s, input logic [KW-1:0] e);
    ks_a = s; ke_a = e; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int k = 0;
    while (!done_a && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, done_a}, 32'd1);
  endtask

  task automatic wait_ps_a(input string tag, input logic [2:0] ph, input logic [KW-1:0] k_want, input bit use_key);
    int k = 0;
    while (!(ps_a == ph && (!use_key || key_a == k_want)) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, (k < 2000)}, 32'd1);
  endtask

  int base, kb;
  int ack_snap;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_key", key_a, 32'd0);
    chk("rst_busy_done", {busy_a, done_a}, 32'd0);
    chk("rst_flags", {found_a, exh_a, abt_a, to_a}, 32'd0);
    chk("rst_phase", {ps_a, pa_a}, 32'd0);
    chk("rst_s", {saddr_a, swdata_a, swren_a}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Match on 0x11 within 0x10..0x12
    match_en_a = 1'b1; match_key_a = 24'h000011;
    base = ps_log_a.size();
    start_search_a(24'h000010, 24'h000012);
    chk("t1_busy", {31'd0, busy_a}, 32'd1);
    wait_done_a("t1_done");
    chk("t1_flags", {found_a, exh_a, abt_a, to_a}, 32'h8);
    chk("t1_found_key", fkey_a, 32'h11);
    chk("t1_attempts", att_a, 32'd2);
    chk("t1_nstarts", ps_log_a.size() - base, 32'd6);
    for (int i = 0; i < 6; i++) chk("t1_seq", ps_log_a[base + i], 32'(3'b001 << (i % 3)));

    // No match: range exhausted
    match_en_a = 1'b0;
    base = ps_log_a.size();
    start_search_a(24'h000010, 24'h000012);
    wait_done_a("t2_done");
    chk("t2_flags", {found_a, exh_a, abt_a, to_a}, 32'h4);
    chk("t2_attempts", att_a, 32'd3);
    chk("t2_key", key_a, 32'h12);
    chk("t2_nstarts", ps_log_a.size() - base, 32'd9);
    chk("t2_last", ps_log_a[ps_log_a.size() - 1], 32'd4);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("t2_ack_per_done", n_ack_a[i], n_done_a[i]);
    // abort while DONE changes nothing
    abort_a = 1'b1; @(negedge clk); abort_a = 1'b0; @(negedge clk);
    chk("t2_abort_idle", {done_a, found_a, exh_a, abt_a, to_a}, 32'h14);

    // Stride 4 near the top of the key space
    kb = key_log_b.size();
    ks_b = 24'hFFFFF9; ke_b = 24'hFFFFFF; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 0; k < 2000 && !done_b; k++) @(negedge clk);
    chk("t3_done", {31'd0, done_b}, 32'd1);
    chk("t3_flags", {found_b, exh_b, abt_b, to_b}, 32'h4);
    chk("t3_attempts", att_b, 32'd2);
    chk("t3_nkeys", key_log_b.size() - kb, 32'd2);
    chk("t3_key0", key_log_b[kb], 32'hFFFFF9);
    chk("t3_key1", key_log_b[kb + 1], 32'hFFFFFD);
    chk("t3_final_key", key_b, 32'hFFFFFD);

    // Watchdog: engine 1 never answers
    hang_a = 3'b010;
    start_search_a(24'h000030, 24'h000040);
    wait_ps_a("t4_ps1", 3'b010, '0, 1'b0);
    repeat (16) @(negedge clk);
    chk("t4_wait16_done", {done_a, to_a}, 32'd0);
    chk("t4_arb", {saddr_a, swdata_a, swren_a}, {7'd0, 8'hA1, 8'hD1, 1'b1});
    @(negedge clk);
    chk("t4_timeout", {done_a, to_a, found_a, exh_a, abt_a}, 32'h18);
    chk("t4_s_wren", {31'd0, swren_a}, 32'd0);
    chk("t4_no_ack", {29'd0, pa_a}, 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_s_wren_hold", {busy_a, swren_a}, 32'd0);
    hang_a = 3'b000;

    // abort coincident with a matching phase-2 done: found wins
    match_en_a = 1'b1; match_key_a = 24'h000040;
    start_search_a(24'h000040, 24'h000045);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk); #1;
      if (pd_a[2]) break;
    end
    chk("t5_pd2", {31'd0, pd_a[2]}, 32'd1);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("t5_flags", {done_a, found_a, exh_a, abt_a, to_a}, 32'h18);
    chk("t5_found_key", fkey_a, 32'h40);

    // abort during phase 1 of key 5
    match_en_a = 1'b0;
    start_search_a(24'h000000, 24'h000020);
    wait_ps_a("t6_ps1_k5", 3'b010, 24'h000005, 1'b1);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("t6_flags", {done_a, found_a, exh_a, abt_a, to_a}, 32'h12);
    chk("t6_attempts", att_a, 32'd5);
    chk("t6_key", key_a, 32'd5);

    // Empty range
    base = ps_log_a.size();
    start_search_a(24'h000020, 24'h000010);
    @(negedge clk);
    chk("t7_flags", {done_a, found_a, exh_a, abt_a, to_a}, 32'h14);
    chk("t7_attempts", att_a, 32'd0);
    chk("t7_no_starts", ps_log_a.size() - base, 32'd0);

    // Reset mid-shuffle
    start_search_a(24'h000050, 24'h000060);
    wait_ps_a("t8_ps1", 3'b010, '0, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t8_key", key_a, 32'd0);
    chk("t8_state", {busy_a, done_a, found_a, exh_a, abt_a, to_a}, 32'd0);
    chk("t8_phase", {ps_a, pa_a}, 32'd0);
    chk("t8_s", {swren_a, saddr_a}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ack_snap = n_ack_a[0] + n_ack_a[1] + n_ack_a[2];
    repeat (6) @(negedge clk);
    chk("t8_no_ack", n_ack_a[0] + n_ack_a[1] + n_ack_a[2], ack_snap);
    chk("t8_idle", {busy_a, done_a}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/rc4_key_search_ctrl.md
Name: rc4_key_search_ctrl

Overview:
Parametrised sequencer for an RC4 brute-force key search. For each candidate key it runs three external sub-engines in turn (0 = S-memory init, 1 = KSA shuffle, 2 = decrypt/check) using start/done/ack handshakes, and owns a registered arbiter onto the shared S-memory port. Compared with the single-stride datapath it replaces, it adds:
- a configurable key stride, so several cores can interleave the key space
- a watchdog on each phase
- an attempt counter
- explicit termination status
It sits between the top-level key-space partitioner and the three phase engines.

Parameters:
KEY_W, 24, width of key and of range bounds
KEY_STRIDE, 1, increment between successive candidate keys (>=1)
ADDR_W, 8, S-memory address width
DATA_W, 8, S-memory data width
TIMEOUT_CYC, 0, maximum cycles allowed in one phase before a timeout error; 0 disables the watchdog

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  begin a search; sampled only in IDLE or DONE
abort  in  1  level; stop the search early
key_start  in  KEY_W  first candidate key, sampled on start
key_end  in  KEY_W  last allowed key (inclusive), sampled on start
key  out  KEY_W  current candidate key, fed to the engines
found_key  out  KEY_W  key that matched, valid while found=1
attempts  out  KEY_W  number of keys fully tested
busy  out  1  high in every state except IDLE and DONE
done  out  1  high while in DONE
found  out  1  termination status: matching key found
exhausted  out  1  termination status: key range finished, no match
aborted  out  1  termination status: stopped by abort
timeout_err  out  1  termination status: watchdog expired
phase_start  out  3  one-hot start pulse to the engines
phase_done  in  3  per-engine done, held until acked
phase_ack  out  3  one-cycle acknowledge per engine
match  in  1  decrypt result; valid when phase_done[2]=1
eng_addr  in  3*ADDR_W  per-engine S address, packed with engine 0 at the LSBs
eng_wdata  in  3*DATA_W  per-engine S write data, same packing
eng_wren  in  3  per-engine write enable
s_addr  out  ADDR_W  registered S address
s_wdata  out  DATA_W  registered S write data
s_wren  out  1  registered S write enable

Behaviour:
- Reset values: state IDLE; phase index ph=0; all outputs 0.
- State machine: IDLE, START_PH, WAIT_PH, DONE. Outputs are Moore; phase_ack is registered.
- Search start (start=1 in IDLE or DONE):
  - latch key_start into key and key_end internally
  - clear attempts, found_key and all four status flags
  - if key_start > key_end: go straight to DONE with exhausted=1 and attempts=0; no phase is started
  - otherwise go to START_PH with ph=0
- START_PH: phase_start[ph]=1 for exactly this cycle; clear the watchdog counter; next state WAIT_PH.
- WAIT_PH with phase_done[ph]=1:
  - phase_ack[ph]=1 on the following cycle, for one cycle only
  - if ph<2: ph increments, next state START_PH
  - if ph=2: attempts increments (saturates at all-ones), then the first matching rule below applies:
    - match=1: found=1, found_key=key, next state DONE
    - (key_end - key) < KEY_STRIDE: exhausted=1, next state DONE. This comparison is done with no overflow, so a key near all-ones never wraps.
    - otherwise: key += KEY_STRIDE, ph=0, next state START_PH
- Watchdog (TIMEOUT_CYC > 0): counts cycles spent in WAIT_PH. When the count reaches TIMEOUT_CYC with phase_done[ph]=0, set timeout_err=1 and go to DONE.
- Abort: abort=1 in START_PH or WAIT_PH sets aborted=1 and goes to DONE next cycle.
- Priority when events coincide in the same cycle: phase-2 done with match=1, then abort, then timeout, then ordinary progress.
- abort in IDLE or DONE has no effect.
- Exactly one status flag is set per search. Flags, found_key and attempts hold until the next start.
- phase_done for engines other than ph is ignored.
- DONE: done=1 until start is received; key holds its last value.
- S-memory arbiter: each cycle the outputs are registered as follows:
  - in START_PH/WAIT_PH: s_addr, s_wdata, s_wren take engine ph's addr, wdata and wren
  - in all other states: s_wren forced to 0, s_addr and s_wdata hold
  - read data is routed to the engines outside this block
- Reset asserted mid-search: everything returns immediately to reset values and no acks are issued. Engines must be reset by the same reset_n.

Test Plan:
- key_start=0x000010, key_end=0x000012, stride 1, engines answer done 5 cycles after start, match=1 on key 0x11 -> found=1, found_key=0x000011, attempts=2; phase_start sequence 1,2,4,1,2,4; one ack per done.
- Same range with match never asserted -> exhausted=1, attempts=3, final key=0x000012, no fourth phase_start[0].
- KEY_STRIDE=4, key_start=0xFFFFF9, key_end=0xFFFFFF, no match -> keys tested 0xFFFFF9 and 0xFFFFFD, then exhausted=1, attempts=2, no wrap to 0x000001.
- TIMEOUT_CYC=16, engine 1 never signals done -> timeout_err=1 on the 16th WAIT_PH cycle; s_wren=0 from then on; done=1.
- abort raised in the same cycle as phase_done[2] with match=1 -> found=1, aborted=0. abort raised during phase 1 of key 5 -> aborted=1, attempts=5.
- key_start=0x20, key_end=0x10 -> done=1 and exhausted=1 two cycles after start, phase_start never asserted. Reset pulsed mid-shuffle -> all outputs 0, state IDLE.
